vjtag_regbank: RTL

Parametrised virtual-JTAG client that generalises the fixed two-LED client into an addressable bank of `NUM_REGS` registers, each `DATA_W` bits wide, with read-back. It sits between the Altera `vjtag` megafunction and the fabric. It is clocked by the virtual JTAG TCK and decodes a 2-bit IR into the BYPASS, ADDR, WRITE and READ instructions. The register contents are exported flat for driving LEDs, control bits or debug muxes.

---
 rtl/vjtag_pkg.sv | 27 ++
 rtl/vjtag_shreg.sv | 39 +++
 rtl/vjtag_regbank.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual-JTAG register bank: IR codes and the
// decode of the three DR-state strobes into a single prioritised scan action.
package vjtag_pkg;

  localparam int VJ_IR_W = 2;

  localparam logic [VJ_IR_W-1:0] VJ_IR_BYPASS = 2'd0;
  localparam logic [VJ_IR_W-1:0] VJ_IR_ADDR   = 2'd1;
  localparam logic [VJ_IR_W-1:0] VJ_IR_WRITE  = 2'd2;
  localparam logic [VJ_IR_W-1:0] VJ_IR_READ   = 2'd3;

  typedef enum logic [1:0] {
    VJ_OP_IDLE,
    VJ_OP_CAPTURE,
    VJ_OP_SHIFT,
    VJ_OP_UPDATE
  } vj_op_e;

  // Capture beats shift beats update, so a protocol glitch still takes one action.
  function automatic vj_op_e vj_decode_op(input logic cdr, input logic sdr, input logic udr);
    if (cdr) return VJ_OP_CAPTURE;
    if (sdr) return VJ_OP_SHIFT;
    if (udr) return VJ_OP_UPDATE;
    return VJ_OP_IDLE;
  endfunction

endpackage

// File: rtl/vjtag_shreg.sv
// Capture/shift register for a JTAG data chain: parallel load on capture,
// LSB-first right shift with tdi entering the MSB.
module vjtag_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         cap,
  input  logic [W-1:0] cap_val,
  input  logic         shift,
  input  logic         tdi,
  output logic [W-1:0] q,
  output logic         lsb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] shifted;

  if (W == 1) begin : g_one
    assign shifted = tdi;
  end else begin : g_wide
    assign shifted = {tdi, sr_q[W-1:1]};
  end

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sr_q <= '0;
    end else if (cap) begin
      sr_q <= cap_val;
    end else if (shift) begin
      sr_q <= shifted;
    end
  end

  assign q   = sr_q;
  assign lsb = sr_q[0];

endmodule

// File: rtl/vjtag_regbank.sv
// Addressable virtual-JTAG register bank with read-back, clocked by TCK.
// Define VJTAG_REGBANK_AUTOINC_EN to auto-increment addr after DR updates.
module vjtag_regbank
  import vjtag_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       tdi,
  output logic                       tdo,
  input  logic [VJ_IR_W-1:0]         ir_in,
  input  logic                       virtual_state_cdr,
  input  logic                       virtual_state_sdr,
  input  logic                       virtual_state_udr,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  vj_op_e              op;
  logic                is_byp, is_addr, is_write, is_read, is_dr;
  logic                addr_valid, wr_fire;
  logic [ADDR_W-1:0]   addr_q, addr_d, asr_val, wr_addr_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_val, dsr_val;
  logic                dsr_lsb, asr_lsb;
  logic                byp_q, byp_d, wr_strobe_q;

  assign op         = vj_decode_op(virtual_state_cdr, virtual_state_sdr, virtual_state_udr);
  assign is_byp     = (ir_in == VJ_IR_BYPASS);
  assign is_addr    = (ir_in == VJ_IR_ADDR);
  assign is_write   = (ir_in == VJ_IR_WRITE);
  assign is_read    = (ir_in == VJ_IR_READ);
  assign is_dr      = is_write | is_read;
  assign addr_valid = ({1'b0, addr_q} < NUM_REGS_W);
  assign rd_val     = addr_valid ? regs_q[addr_q] : '0;
  assign wr_fire    = (op == VJ_OP_UPDATE) && is_write && addr_valid;

  vjtag_shreg #(.W(DATA_W)) u_dsr (
    .clk     (clk),
    .reset_  (reset_),
    .cap     ((op == VJ_OP_CAPTURE) && is_dr),
    .cap_val (rd_val),
    .shift   ((op == VJ_OP_SHIFT) && is_dr),
    .tdi     (tdi),
    .q       (dsr_val),
    .lsb     (dsr_lsb)
  );

  vjtag_shreg #(.W(ADDR_W)) u_asr (
    .clk     (clk),
    .reset_  (reset_),
    .cap     ((op == VJ_OP_CAPTURE) && is_addr),
    .cap_val (addr_q),
    .shift   ((op == VJ_OP_SHIFT) && is_addr),
    .tdi     (tdi),
    .q       (asr_val),
    .lsb     (asr_lsb)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    if (op == VJ_OP_UPDATE) begin
      if (is_addr) begin
        addr_d = asr_val;
      end
`ifdef VJTAG_REGBANK_AUTOINC_EN
      else if (is_dr && addr_valid) begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    byp_d = byp_q;
    if (is_byp) begin
      if (op == VJ_OP_CAPTURE)    byp_d = 1'b0;
      else if (op == VJ_OP_SHIFT) byp_d = tdi;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      addr_q      <= '0;
      byp_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      byp_q       <= byp_d;
      wr_strobe_q <= wr_fire;
      if (wr_fire) wr_addr_q <= addr_q;
    end
  end

  // NOTE: the bank is reset (unlike a RAM) because regs_out drives fabric controls.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_fire && (addr_q == ADDR_W'(k))) regs_q[k] <= dsr_val;
      end
    end
  end

  always_comb begin
    tdo = dsr_lsb;
    case (ir_in)
      VJ_IR_BYPASS: tdo = byp_q;
      VJ_IR_ADDR:   tdo = asr_lsb;
      default:      tdo = dsr_lsb;
    endcase
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule
